// File: rtl/riscv_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: ID operand/destination info in, stall/flush/forwarding controls out.
interface riscv_hazard_ctrl_if #(
    parameter int unsigned NREG = 32
);
    localparam int unsigned AW = $clog2(NREG);

    logic          freeze;
    logic          id_valid;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic          id_use_rs1;
    logic          id_use_rs2;
    logic [AW-1:0] id_rd;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          ex_redirect;

    logic          pc_hold;
    logic          ifid_hold;
    logic          idex_bubble;
    logic          ifid_flush;
    logic          idex_flush;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic [31:0]   stall_cnt;
    logic [31:0]   flush_cnt;

    modport master (
        output freeze, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_write, id_mem_read, ex_redirect,
        input  pc_hold, ifid_hold, idex_bubble, ifid_flush, idex_flush,
               fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  freeze, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_reg_write, id_mem_read, ex_redirect,
        output pc_hold, ifid_hold, idex_bubble, ifid_flush, idex_flush,
               fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/riscv_hazard_ctrl.sv
// Hazard/forwarding controller for a 5-stage pipeline using a shadow EX/MEM/WB destination pipe.
// Optional stall/flush performance counters are enabled with `define HAZ_PERF_EN.
module riscv_hazard_ctrl #(
    parameter int unsigned NREG          = 32,
    parameter bit          RF_WRITE_THRU = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    riscv_hazard_ctrl_if.slave  hz
);
    localparam int unsigned AW    = $clog2(NREG);
    localparam int unsigned CNT_W = 32;

    typedef struct packed {
        logic          v;
        logic [AW-1:0] rd;
        logic          wr;
        logic          ld;
    } shadow_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_e;

    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_FREEZE,
        MODE_FLUSH,
        MODE_STALL
    } mode_e;

    shadow_t ex_q, mem_q, wb_q;
    shadow_t ex_d, mem_d, wb_d;
    fwd_e    fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
    mode_e   mode_c;

    logic m1_ex_c, m2_ex_c, m1_mem_c, m2_mem_c, m1_wb_c, m2_wb_c;
    logic load_use_c, wb_hazard_c, stall_c;
    logic pc_hold_c, ifid_hold_c, idex_bubble_c, ifid_flush_c, idex_flush_c;

    function automatic logic is_prod(input shadow_t e);
        return e.v & e.wr & (e.rd != '0);
    endfunction

    function automatic fwd_e sel_fwd(input logic ex_hit, input logic mem_hit);
        if (ex_hit)       return FWD_MEM;
        else if (mem_hit) return FWD_WB;
        else              return FWD_RF;
    endfunction

    // Operand matches against each shadow stage
    assign m1_ex_c  = hz.id_valid & hz.id_use_rs1 & is_prod(ex_q)  & (ex_q.rd  == hz.id_rs1);
    assign m2_ex_c  = hz.id_valid & hz.id_use_rs2 & is_prod(ex_q)  & (ex_q.rd  == hz.id_rs2);
    assign m1_mem_c = hz.id_valid & hz.id_use_rs1 & is_prod(mem_q) & (mem_q.rd == hz.id_rs1);
    assign m2_mem_c = hz.id_valid & hz.id_use_rs2 & is_prod(mem_q) & (mem_q.rd == hz.id_rs2);
    assign m1_wb_c  = hz.id_valid & hz.id_use_rs1 & is_prod(wb_q)  & (wb_q.rd  == hz.id_rs1);
    assign m2_wb_c  = hz.id_valid & hz.id_use_rs2 & is_prod(wb_q)  & (wb_q.rd  == hz.id_rs2);

    assign load_use_c = ex_q.ld & (m1_ex_c | m2_ex_c);

    // WB producer is invisible to forwarding; stall unless the reg file writes through
    always_comb begin
        wb_hazard_c = 1'b0;
        if (!RF_WRITE_THRU) begin
            wb_hazard_c = (m1_wb_c & ~m1_ex_c & ~m1_mem_c) |
                          (m2_wb_c & ~m2_ex_c & ~m2_mem_c);
        end
    end

    assign stall_c = load_use_c | wb_hazard_c;

    always_comb begin
        mode_c = MODE_RUN;
        if (hz.freeze)           mode_c = MODE_FREEZE;
        else if (hz.ex_redirect) mode_c = MODE_FLUSH;
        else if (stall_c)        mode_c = MODE_STALL;
    end

    always_comb begin
        pc_hold_c     = 1'b0;
        ifid_hold_c   = 1'b0;
        idex_bubble_c = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        if (reset) begin
            case (mode_c)
                MODE_FREEZE: begin
                    pc_hold_c   = 1'b1;
                    ifid_hold_c = 1'b1;
                end
                MODE_FLUSH: begin
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                end
                MODE_STALL: begin
                    pc_hold_c     = 1'b1;
                    ifid_hold_c   = 1'b1;
                    idex_bubble_c = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Shadow pipe and forwarding selects advance with the ID->EX register
    always_comb begin
        ex_d    = ex_q;
        mem_d   = mem_q;
        wb_d    = wb_q;
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (mode_c != MODE_FREEZE) begin
            ex_d    = '0;
            mem_d   = ex_q;
            wb_d    = mem_q;
            fwd_a_d = FWD_RF;
            fwd_b_d = FWD_RF;
            if (mode_c == MODE_RUN) begin
                ex_d.v  = hz.id_valid;
                ex_d.rd = hz.id_rd;
                ex_d.wr = hz.id_reg_write;
                ex_d.ld = hz.id_mem_read;
                fwd_a_d = sel_fwd(m1_ex_c & ~ex_q.ld, m1_mem_c);
                fwd_b_d = sel_fwd(m2_ex_c & ~ex_q.ld, m2_mem_c);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign hz.pc_hold     = pc_hold_c;
    assign hz.ifid_hold   = ifid_hold_c;
    assign hz.idex_bubble = idex_bubble_c;
    assign hz.ifid_flush  = ifid_flush_c;
    assign hz.idex_flush  = idex_flush_c;
    assign hz.fwd_a       = fwd_a_q;
    assign hz.fwd_b       = fwd_b_q;

`ifdef HAZ_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating event counters; frozen cycles never count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((mode_c == MODE_STALL) && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if ((mode_c == MODE_FLUSH) && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`else
    assign hz.stall_cnt = CNT_W'(0);
    assign hz.flush_cnt = CNT_W'(0);
`endif

endmodule
